// File: rtl/button_event_arbiter_if.sv
// rtl/button_event_arbiter_if.sv - event offer handshake between arbiter and consumer
interface button_event_arbiter_if #(
    parameter int NUM_BUTTONS = 4
);
    localparam int ID_WIDTH = $clog2(NUM_BUTTONS);

    logic                evt_valid;
    logic                evt_ready;
    logic [ID_WIDTH-1:0] evt_id;

    modport master (output evt_valid, output evt_id, input evt_ready);
    modport slave  (input evt_valid, input evt_id, output evt_ready);
endinterface

// File: rtl/button_event_arbiter.sv
// rtl/button_event_arbiter.sv - round-robin arbiter of button edge pulses onto one valid/ready stream
module button_event_arbiter #(
    parameter int NUM_BUTTONS = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_BUTTONS-1:0] btn_event_i,
    input  logic [NUM_BUTTONS-1:0] clear_lost_i,
    output logic [NUM_BUTTONS-1:0] pending_o,
    output logic [NUM_BUTTONS-1:0] evt_lost_o,
    button_event_arbiter_if.master bus
);
    localparam int ID_WIDTH = $clog2(NUM_BUTTONS);

    typedef enum logic {IDLE, OFFER} state_t;

    state_t                 state_q, state_d;
    logic [NUM_BUTTONS-1:0] pending_q, pending_d;
    logic [NUM_BUTTONS-1:0] lost_q, lost_d;
    logic [ID_WIDTH-1:0]    last_q, last_d;
    logic [ID_WIDTH-1:0]    evt_id_q, evt_id_d;

    logic                   found;
    logic [ID_WIDTH-1:0]    sel_idx;
    logic                   take;
    logic [NUM_BUTTONS-1:0] grant;
    int unsigned            idx;

    // Search starts just after the last winner, so only registered pending bits compete.
    always_comb begin
        found   = 1'b0;
        sel_idx = '0;
        idx     = 0;
        for (int k = 1; k <= NUM_BUTTONS; k++) begin
            idx = (int'(last_q) + k) % NUM_BUTTONS;
            if (!found && pending_q[idx]) begin
                found   = 1'b1;
                sel_idx = ID_WIDTH'(idx);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        evt_id_d = evt_id_q;
        last_d   = last_q;
        take     = 1'b0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    take    = 1'b1;
                    state_d = OFFER;
                end
            end
            OFFER: begin
                if (bus.evt_ready) begin
                    if (found) take = 1'b1;
                    else       state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (take) begin
            evt_id_d = sel_idx;
            last_d   = sel_idx;
        end
    end

    // A pulse on a bit being granted this cycle re-arms it rather than counting as an overrun.
    always_comb begin
        grant     = take ? (NUM_BUTTONS'(1) << sel_idx) : '0;
        pending_d = (pending_q & ~grant) | btn_event_i;
        lost_d    = (lost_q & ~clear_lost_i) | (btn_event_i & pending_q & ~grant);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pending_q <= '0;
            lost_q    <= '0;
            last_q    <= ID_WIDTH'(NUM_BUTTONS - 1);
            evt_id_q  <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            lost_q    <= lost_d;
            last_q    <= last_d;
            evt_id_q  <= evt_id_d;
        end
    end

    assign bus.evt_valid = (state_q == OFFER);
    assign bus.evt_id    = evt_id_q;
    assign pending_o     = pending_q;
    assign evt_lost_o    = lost_q;
endmodule

// File: tb/tb_button_event_arbiter.sv
// tb/tb_button_event_arbiter.sv - directed self-checking bench for button_event_arbiter
module tb_button_event_arbiter;
    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] btn = '0;
    logic [N-1:0] clr = '0;
    logic [N-1:0] pending;
    logic [N-1:0] lost;
    int           n_cmp = 0;
    int           n_err = 0;

    button_event_arbiter_if #(.NUM_BUTTONS(N)) bus ();

    button_event_arbiter #(.NUM_BUTTONS(N)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .btn_event_i  (btn),
        .clear_lost_i (clr),
        .pending_o    (pending),
        .evt_lost_o   (lost),
        .bus          (bus.master)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        btn = '0;
        clr = '0;
        bus.evt_ready = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        btn = 4'b0110;
        step();
        btn = '0;
        step();
        step();
        n_cmp++;
        if (bus.evt_valid !== 1'b1) begin
            n_err++;
            $display("FAIL reset_pre_offer valid: got %b want 1", bus.evt_valid);
        end
        rst_n = 1'b0;
        #2;
        n_cmp++;
        if ({bus.evt_valid, bus.evt_id, pending, lost} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: valid=%b id=%0d pend=%b lost=%b want all 0",
                     bus.evt_valid, bus.evt_id, pending, lost);
        end
        step();
        rst_n = 1'b1;
        step();
        n_cmp++;
        if ({bus.evt_valid, pending, lost} !== '0) begin
            n_err++;
            $display("FAIL reset_after_release: valid=%b pend=%b lost=%b want 0", bus.evt_valid, pending, lost);
        end
        btn = 4'b0001;
        step();
        btn = '0;
        n_cmp++;
        if (pending !== 4'b0001 || bus.evt_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_latency1: pend=%b valid=%b want 0001/0", pending, bus.evt_valid);
        end
        step();
        n_cmp++;
        if (bus.evt_valid !== 1'b1 || bus.evt_id !== 2'd0) begin
            n_err++;
            $display("FAIL reset_latency2: valid=%b id=%0d want 1/0", bus.evt_valid, bus.evt_id);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        bus.evt_ready = 1'b1;
        btn = 4'b1111;
        step();
        btn = '0;
        n_cmp++;
        if (pending !== 4'b1111 || bus.evt_valid !== 1'b0) begin
            n_err++;
            $display("FAIL simul_pending: pend=%b valid=%b want 1111/0", pending, bus.evt_valid);
        end
        for (int i = 0; i < N; i++) begin
            step();
            n_cmp++;
            if (bus.evt_valid !== 1'b1 || bus.evt_id !== 2'(i)) begin
                n_err++;
                $display("FAIL simul_id%0d: valid=%b id=%0d want 1/%0d", i, bus.evt_valid, bus.evt_id, i);
            end
        end
        step();
        n_cmp++;
        if (bus.evt_valid !== 1'b0 || lost !== 4'b0000 || pending !== 4'b0000) begin
            n_err++;
            $display("FAIL simul_end: valid=%b lost=%b pend=%b want 0/0000/0000", bus.evt_valid, lost, pending);
        end
    endtask

    task automatic test_fairness();
        do_reset();
        bus.evt_ready = 1'b1;
        btn = 4'b0100;
        step();
        step();
        n_cmp++;
        if (bus.evt_id !== 2'd2 || bus.evt_valid !== 1'b1) begin
            n_err++;
            $display("FAIL fair_first: id=%0d valid=%b want 2/1", bus.evt_id, bus.evt_valid);
        end
        btn = 4'b0110;
        step();
        btn = 4'b0100;
        step();
        btn = '0;
        n_cmp++;
        if (bus.evt_id !== 2'd1 || lost !== 4'b0100) begin
            n_err++;
            $display("FAIL fair_grant1: id=%0d lost=%b want 1/0100", bus.evt_id, lost);
        end
        step();
        n_cmp++;
        if (bus.evt_id !== 2'd2 || bus.evt_valid !== 1'b1) begin
            n_err++;
            $display("FAIL fair_back2: id=%0d valid=%b want 2/1", bus.evt_id, bus.evt_valid);
        end
        step();
        n_cmp++;
        if (bus.evt_valid !== 1'b0 || lost !== 4'b0100) begin
            n_err++;
            $display("FAIL fair_end: valid=%b lost=%b want 0/0100", bus.evt_valid, lost);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        btn = 4'b1000;
        step();
        btn = '0;
        step();
        for (int c = 0; c < 10; c++) begin
            btn = (c == 2 || c == 5) ? 4'b1000 : 4'b0000;
            step();
            btn = '0;
            n_cmp++;
            if (bus.evt_valid !== 1'b1 || bus.evt_id !== 2'd3) begin
                n_err++;
                $display("FAIL bp_stable%0d: valid=%b id=%0d want 1/3", c, bus.evt_valid, bus.evt_id);
            end
            if (c == 2) begin
                n_cmp++;
                if (pending !== 4'b1000 || lost !== 4'b0000) begin
                    n_err++;
                    $display("FAIL bp_rearm: pend=%b lost=%b want 1000/0000", pending, lost);
                end
            end
            if (c == 5) begin
                n_cmp++;
                if (lost !== 4'b1000) begin
                    n_err++;
                    $display("FAIL bp_overrun: lost=%b want 1000", lost);
                end
            end
        end
        bus.evt_ready = 1'b1;
        step();
        n_cmp++;
        if (bus.evt_valid !== 1'b1 || bus.evt_id !== 2'd3 || pending !== 4'b0000) begin
            n_err++;
            $display("FAIL bp_second: valid=%b id=%0d pend=%b want 1/3/0000", bus.evt_valid, bus.evt_id, pending);
        end
        step();
        n_cmp++;
        if (bus.evt_valid !== 1'b0) begin
            n_err++;
            $display("FAIL bp_drain: valid=%b want 0", bus.evt_valid);
        end
    endtask

    task automatic test_lost_clear();
        do_reset();
        btn = 4'b0010;
        step();
        btn = '0;
        step();
        btn = 4'b0010;
        step();
        clr = 4'b0010;
        step();
        btn = '0;
        n_cmp++;
        if (lost !== 4'b0010) begin
            n_err++;
            $display("FAIL lost_race: lost=%b want 0010", lost);
        end
        step();
        clr = '0;
        n_cmp++;
        if (lost !== 4'b0000) begin
            n_err++;
            $display("FAIL lost_clear: lost=%b want 0000", lost);
        end
    endtask

    task automatic test_same_cycle_rearm();
        do_reset();
        btn = 4'b0001;
        step();
        step();
        btn = '0;
        n_cmp++;
        if (bus.evt_valid !== 1'b1 || bus.evt_id !== 2'd0 || pending !== 4'b0001 || lost !== 4'b0000) begin
            n_err++;
            $display("FAIL rearm_grant: valid=%b id=%0d pend=%b lost=%b want 1/0/0001/0000",
                     bus.evt_valid, bus.evt_id, pending, lost);
        end
        bus.evt_ready = 1'b1;
        step();
        n_cmp++;
        if (bus.evt_valid !== 1'b1 || bus.evt_id !== 2'd0 || pending !== 4'b0000) begin
            n_err++;
            $display("FAIL rearm_second: valid=%b id=%0d pend=%b want 1/0/0000", bus.evt_valid, bus.evt_id, pending);
        end
        step();
        n_cmp++;
        if (bus.evt_valid !== 1'b0 || lost !== 4'b0000) begin
            n_err++;
            $display("FAIL rearm_end: valid=%b lost=%b want 0/0000", bus.evt_valid, lost);
        end
    endtask

    initial begin
        bus.evt_ready = 1'b0;
        test_reset();
        test_simultaneous();
        test_fairness();
        test_backpressure();
        test_lost_clear();
        test_same_cycle_rearm();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/button_event_arbiter.md
# button_event_arbiter

Collects single-cycle debounced edge pulses from up to NUM_BUTTONS button detectors and hands them, one at a time, to a single consumer over a valid/ready handshake. Each button gets a one-deep pending latch. Selection among pending buttons is round-robin, so a chattering or held button cannot starve the others. An event that arrives while its button is already pending is counted as an overrun and reported through a sticky per-button flag. The block sits between the bank of button detectors and the control logic or register interface that acts on button presses.

## Interface
- NUM_BUTTONS, 4, number of button event inputs; legal range 2..16.
- ID_WIDTH, $clog2(NUM_BUTTONS) (localparam), width of the event index.

- CLK  in  1  system clock; all state updates on its rising edge.
- RESETN  in  1  asynchronous, active-low reset.
- BTN_EVENT  in  NUM_BUTTONS  bit i is a one-cycle pulse per debounced edge of button i; multiple bits may be high in the same cycle.
- EVT_VALID  out  1  an event is being offered on EVT_ID.
- EVT_READY  in  1  consumer accepts; a transfer occurs on any edge where EVT_VALID=1 and EVT_READY=1.
- EVT_ID  out  ID_WIDTH  index of the offered button.
- PENDING  out  NUM_BUTTONS  registered pending latches: bit i means an event for button i is waiting and has not yet been selected.
- EVT_LOST  out  NUM_BUTTONS  sticky overrun flags.
- CLEAR_LOST  in  NUM_BUTTONS  write-1-to-clear strobes for EVT_LOST.

## Operation
- Registers:
  - PENDING[N]
  - EVT_LOST[N]
  - LAST: index of the last granted button.
  - State: IDLE or OFFER.
  - EVT_ID, with EVT_VALID = (state == OFFER).
- Grant selection:
  - Computed from the registered PENDING only. A BTN_EVENT pulse is never eligible in the same cycle it arrives.
  - Search order is LAST+1, LAST+2, … modulo NUM_BUTTONS.
  - The first set bit found is the grant (one-hot GRANT, index G).
- IDLE:
  - If PENDING is nonzero: load EVT_ID=G, set LAST=G, clear PENDING[G], go to OFFER.
  - Otherwise remain in IDLE.
- OFFER:
  - While EVT_READY=0, EVT_ID and EVT_VALID hold stable.
  - On a transfer with PENDING nonzero: select and load the next grant in the same cycle and stay in OFFER, giving back-to-back events.
  - On a transfer with PENDING zero: go to IDLE.
- Pending update, every cycle: PENDING_next = (PENDING & ~GRANT) | BTN_EVENT. GRANT is zero when no selection occurs.
- Overrun: EVT_LOST[i] is set when BTN_EVENT[i] & PENDING[i] & ~GRANT[i].
  - A pulse arriving in the same cycle its own pending bit is granted is not an overrun; it re-arms PENDING[i].
  - A pulse for the button currently being offered (already removed from PENDING) re-arms PENDING and is not an overrun.
- CLEAR_LOST[i] clears EVT_LOST[i]. If a set condition and a clear occur in the same cycle, the set wins.
- Reset values:
  - EVT_VALID=0, EVT_ID=0, PENDING=0, EVT_LOST=0.
  - LAST=NUM_BUTTONS-1, so button 0 has first priority.
  - State=IDLE.
- Reset asserted mid-operation: an offered or pending event is discarded silently, with no EVT_LOST indication.

## Timing
- Pulse latency:
  - BTN_EVENT[i] sampled high at edge k.
  - PENDING[i]=1 after edge k.
  - If idle, EVT_VALID=1 and EVT_ID=i after edge k+1, so 2 cycles from pulse to offer.
- Throughput: with EVT_READY held at 1 and work pending, one transfer per cycle, with no idle bubble between events.
- EVT_ID changes only on an edge where the state leaves IDLE or a transfer occurs.
- Every output is driven directly from a register; there are no combinational paths from inputs to outputs.

## Test plan
- Reset: assert RESETN=0 mid-offer, then release -> all outputs 0, EVT_VALID=0; the next single pulse on button 0 yields EVT_VALID 2 cycles later with EVT_ID=0.
- Simultaneous pulses: NUM_BUTTONS=4, BTN_EVENT=4'b1111 for one cycle, EVT_READY=1 -> EVT_IDs 0,1,2,3 on consecutive cycles, then EVT_VALID=0; EVT_LOST=0.
- Fairness: button 2 pulses every cycle while button 1 pulses once, EVT_READY=1 -> button 1 is granted within 2 transfers of becoming pending; EVT_LOST[2] is set.
- Backpressure: pulse button 3, hold EVT_READY=0 for 10 cycles -> EVT_ID=3 stays stable and EVT_VALID stays 1; a second pulse on button 3 during the stall sets PENDING[3] without setting EVT_LOST[3]; a third pulse sets EVT_LOST[3].
- Lost clear race: CLEAR_LOST[1]=1 in the same cycle as a new overrun on button 1 -> EVT_LOST[1] remains 1; CLEAR_LOST[1] one cycle later -> EVT_LOST[1]=0.
- Same-cycle re-arm: pulse button 0 in the cycle its pending bit is granted -> PENDING[0]=1 afterwards, EVT_LOST[0]=0, and a second transfer with EVT_ID=0 follows.
